// File: rtl/alu.sv
// Registered 32-bit integer ALU with zero/carry/negative/overflow flags.
// One operation per cycle, results visible one edge after sampling.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluc,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADDU = 4'b0000;
  localparam logic [3:0] OP_SUBU = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_LUI0 = 4'b1000;
  localparam logic [3:0] OP_LUI1 = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;
  localparam logic [3:0] OP_SLT  = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1100;
  localparam logic [3:0] OP_SRL  = 4'b1101;
  localparam logic [3:0] OP_SLL0 = 4'b1110;
  localparam logic [3:0] OP_SLL1 = 4'b1111;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic             ltu;
  logic             lts;
  logic [SW-1:0]    sh;
  logic [WIDTH:0]   rext;
  logic [WIDTH:0]   lext;
  logic [SW:0]      lidx;

  logic [WIDTH-1:0] res;
  logic             c;
  logic             n;
  logic             v;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = a - b;
  assign ltu  = a < b;
  assign lts  = $signed(a) < $signed(b);
  assign sh   = a[SW-1:0];

  // Padded copies so a zero shift amount selects the constant 0 as carry.
  assign rext = {b, 1'b0};
  assign lext = {1'b0, b};
  assign lidx = (SW + 1)'(WIDTH) - {1'b0, sh};

  always_comb begin
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    n   = 1'b0;
    case (aluc)
      OP_ADDU: begin
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
      end
      OP_ADD: begin
        res = sum[WIDTH-1:0];
        v   = (a[WIDTH-1] == b[WIDTH-1]) &&
              (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUBU: begin
        res = diff;
        c   = ltu;
      end
      OP_SUB: begin
        res = diff;
        v   = (a[WIDTH-1] != b[WIDTH-1]) &&
              (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOR: res = ~(a | b);
      OP_LUI0, OP_LUI1: res = {b[15:0], 16'h0000};
      OP_SLTU: begin
        res = WIDTH'(ltu);
        c   = ltu;
      end
      OP_SLT: res = WIDTH'(lts);
      OP_SRA: begin
        res = $signed(b) >>> sh;
        c   = rext[sh];
      end
      OP_SRL: begin
        res = b >> sh;
        c   = rext[sh];
      end
      OP_SLL0, OP_SLL1: begin
        res = b << sh;
        c   = lext[lidx];
      end
      default: res = '0;
    endcase
    n = (aluc == OP_SLT) ? lts : res[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      negative <= 1'b0;
      overflow <= 1'b0;
    end else begin
      result   <= res;
      zero     <= (res == '0);
      carry    <= c;
      negative <= n;
      overflow <= v;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the registered ALU.
// Expected values are hand-computed constants.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  aluc;
  logic [31:0] result;
  logic        zero;
  logic        carry;
  logic        negative;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  alu #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .a(a),
    .b(b),
    .aluc(aluc),
    .result(result),
    .zero(zero),
    .carry(carry),
    .negative(negative),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag,
                           input logic [31:0] r,
                           input logic z, input logic c,
                           input logic n, input logic v);
    check({tag, ".res"}, result, r);
    check({tag, ".z"}, {31'b0, zero}, {31'b0, z});
    check({tag, ".c"}, {31'b0, carry}, {31'b0, c});
    check({tag, ".n"}, {31'b0, negative}, {31'b0, n});
    check({tag, ".v"}, {31'b0, overflow}, {31'b0, v});
  endtask

  task automatic step(input logic [31:0] ta,
                      input logic [31:0] tb,
                      input logic [3:0]  op);
    a    = ta;
    b    = tb;
    aluc = op;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] sweep_exp [16];

  initial begin
    sweep_exp = '{32'h0000_0020, 32'hFFFF_FFA0, 32'h0000_0020,
                  32'hFFFF_FFA0, 32'h0000_0040, 32'hFFFF_FFE0,
                  32'hFFFF_FFA0, 32'h0000_001F, 32'h0040_0000,
                  32'h0040_0000, 32'h0000_0000, 32'h0000_0001,
                  32'h0000_0040, 32'h0000_0040, 32'h0000_0040,
                  32'h0000_0040};

    rst = 1'b1;
    a = 32; b = 64; aluc = 4'b0000;
    @(posedge clk); #1;
    check_all("rst1", 32'h0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check_all("rst2", 32'h0, 0, 0, 0, 0);
    rst = 1'b0;

    step(32, 64, 4'b0000);
    check_all("addu96", 32'd96, 0, 0, 0, 0);
    step(32, 64, 4'b0001);
    check_all("subu", 32'hFFFF_FFE0, 0, 1, 1, 0);
    step(32, 64, 4'b1011);
    check_all("slt", 32'h1, 0, 0, 1, 0);
    step(32, 64, 4'b1010);
    check_all("sltu", 32'h1, 0, 1, 0, 0);

    step(32'h7FFF_FFFF, 1, 4'b0010);
    check_all("add_ovf", 32'h8000_0000, 0, 0, 1, 1);
    step(32'h7FFF_FFFF, 1, 4'b0000);
    check_all("addu_noc", 32'h8000_0000, 0, 0, 1, 0);

    step(32'hFFFF_FFFF, 32'h7FFF_FFFF, 4'b0000);
    check_all("addu_c", 32'h7FFF_FFFE, 0, 1, 0, 0);
    step(32'hFFFF_FFFF, 32'h7FFF_FFFF, 4'b0011);
    check_all("sub_nov", 32'h8000_0000, 0, 0, 1, 0);
    step(32'hFFFF_FFFF, 32'h7FFF_FFFF, 4'b0111);
    check_all("nor0", 32'h0, 1, 0, 0, 0);
    step(32'h8000_0000, 1, 4'b0011);
    check_all("sub_ovf", 32'h7FFF_FFFF, 0, 0, 0, 1);
    step(32'hF0F0_1234, 32'h0FF0_FFFF, 4'b0110);
    check_all("xor", 32'hFF00_EDCB, 0, 0, 1, 0);

    step(15, 32'h8000_0000, 4'b1100);
    check_all("sra", 32'hFFFF_0000, 0, 0, 1, 0);
    step(15, 32'h8000_0000, 4'b1101);
    check_all("srl", 32'h0001_0000, 0, 0, 0, 0);
    step(15, 32'h8000_0000, 4'b1110);
    check_all("sll", 32'h0, 1, 0, 0, 0);
    step(32, 32'h8000_0000, 4'b1101);
    check_all("srl0", 32'h8000_0000, 0, 0, 1, 0);
    step(1, 3, 4'b1101);
    check_all("srl_c", 32'h1, 0, 1, 0, 0);
    step(4, 32'h0000_0018, 4'b1100);
    check_all("sra_c", 32'h1, 0, 1, 0, 0);
    step(1, 32'h8000_0001, 4'b1111);
    check_all("sll_c", 32'h2, 0, 1, 0, 0);

    step(-32, 64, 4'b1000);
    check_all("lui", 32'h0040_0000, 0, 0, 0, 0);

    // Mid-stream reset must discard the sampled operation.
    rst = 1'b1;
    step(32'h1234_5678, 1, 4'b0000);
    check_all("rst_mid", 32'h0, 0, 0, 0, 0);
    rst = 1'b0;

    a = -32; b = 64;
    for (int k = 0; k < 16; k++) begin
      aluc = 4'(k);
      #3;
      if (k > 0)
        check($sformatf("pre%0d", k), result, sweep_exp[k-1]);
      @(posedge clk);
      #1;
      check($sformatf("sweep%0d", k), result, sweep_exp[k]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit registered integer ALU for the team's single-cycle/multicycle MIPS-style datapath.
- Computes one of 16 `aluc`-selected operations on operands `a` and `b`.
- Registers the result and four status flags (zero, carry, negative, overflow) on the rising clock edge.
- Feeds the writeback/branch logic of the CPU core.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is required to be supported.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous reset, active-high
- a  input  32  operand A; shift amount source for shift ops
- b  input  32  operand B; shifted value for shift ops; immediate source for LUI
- aluc  input  4  operation select
- result  output  32  registered result
- zero  output  1  registered flag
- carry  output  1  registered flag
- negative  output  1  registered flag
- overflow  output  1  registered flag

Interface note: one clock; reset is synchronous and active-high.

Behaviour:
- All outputs are registered with a latency of 1 cycle: inputs sampled at edge N appear on the outputs after edge N. There is no handshake; a new operation is accepted every cycle.
- Reset: at a clk edge with rst=1, result=0 and zero=carry=negative=overflow=0. rst has priority over computation. Mid-stream reset discards the in-flight operation.
- Operations by aluc:
  - 0000 ADDU: result=a+b mod 2^32; carry=unsigned carry-out of bit 31.
  - 0010 ADD: result=a+b; overflow=1 when signs of a and b are equal and the result sign differs.
  - 0001 SUBU: result=a-b; carry=1 iff a<b unsigned (borrow).
  - 0011 SUB: result=a-b; overflow=1 when signs of a and b differ and the result sign differs from a.
  - 0100 AND, 0101 OR, 0110 XOR, 0111 NOR: bitwise.
  - 1000 and 1001 LUI: result={b[15:0],16'h0000}.
  - 1011 SLT: result=1 if $signed(a)<$signed(b), else 0; negative=the same comparison bit.
  - 1010 SLTU: result=1 if a<b unsigned, else 0; carry=the same comparison bit.
  - 1100 SRA: result=$signed(b)>>>a[4:0].
  - 1101 SRL: result=b>>a[4:0].
  - 1110 and 1111 SLL: result=b<<a[4:0].
  - Shift carry rules: for SRA/SRL, carry=last bit shifted out, i.e. b[a[4:0]-1]. For SLL, carry=b[32-a[4:0]]. For a shift amount of 0, result=b and carry=0. Bits a[31:5] are ignored.
- Flags:
  - zero=(result==0) for every operation.
  - negative=result[31] for every operation except SLT, which uses the comparison bit.
  - carry: 0 for every operation not listed above.
  - overflow: 0 for every operation except ADD and SUB.
- Arithmetic wraps modulo 2^32. No exceptions or traps are raised; overflow is a flag only.

Test Plan:
- rst=1 for 2 edges with a=32, b=64, aluc=0000 -> all outputs 0. Release rst -> next edge result=96, zero=0, carry=0.
- a=32, b=64, aluc=0001 (SUBU) -> result=0xFFFFFFE0, carry=1, negative=1. aluc=1011 (SLT) -> result=1, negative=1. aluc=1010 (SLTU) -> result=1, carry=1.
- a=0x7FFFFFFF, b=1, aluc=0010 (ADD) -> result=0x80000000, overflow=1, negative=1. Same operands with aluc=0000 (ADDU) -> overflow=0, carry=0.
- a=0xFFFFFFFF, b=0x7FFFFFFF, aluc=0000 -> result=0x7FFFFFFE, carry=1. aluc=0011 (SUB) -> result=0x80000000, overflow=0, negative=1. aluc=0111 (NOR) -> result=0, zero=1.
- a=15, b=0x80000000 shifts:
  - aluc=1100 (SRA) -> result=0xFFFF0000, carry=0.
  - aluc=1101 (SRL) -> result=0x00010000.
  - aluc=1110 (SLL) -> result=0, zero=1.
  - a=32 with aluc=1101 -> result=0x80000000, carry=0 (shift amount 0).
- a=-32, b=64, aluc=1000 (LUI) -> result=0x00400000. Sweep aluc 0..15 back-to-back -> each result appears exactly one cycle after its aluc is applied.
